// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the control sequencer: state enumeration, opcode and
// ALU operation codes, instruction-register field positions, decode helpers.
package control_sequencer_pkg;

  localparam int unsigned IR_W     = 32;
  localparam int unsigned OPCODE_W = 5;
  localparam int unsigned REG_W    = 4;
  localparam int unsigned NREGS    = 16;
  localparam int unsigned ALUOP_W  = 5;

  // Instruction field positions (LSB of each field)
  localparam int unsigned OPCODE_LSB = 27;
  localparam int unsigned RA_LSB     = 23;
  localparam int unsigned RB_LSB     = 19;
  localparam int unsigned RC_LSB     = 15;

  typedef enum logic [2:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_HALT
  } state_e;

  localparam logic [OPCODE_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPCODE_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPCODE_W-1:0] OP_AND = 5'b01000;
  localparam logic [OPCODE_W-1:0] OP_OR  = 5'b01001;

  localparam logic [ALUOP_W-1:0] ALU_NOP = 5'b00000;
  localparam logic [ALUOP_W-1:0] ALU_ADD = 5'b00100;
  localparam logic [ALUOP_W-1:0] ALU_SUB = 5'b00101;
  localparam logic [ALUOP_W-1:0] ALU_AND = 5'b01001;
  localparam logic [ALUOP_W-1:0] ALU_OR  = 5'b01010;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Illegal opcodes map to NOP; they never reach the execute step anyway.
  function automatic logic [ALUOP_W-1:0] alu_code(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_reg_select_decoder.sv
// 4-to-16 one-hot decoder with enable, used for general-register selects.
// Ports: en (enable), sel (register index), onehot (one-hot select, 0 when en=0).
module reg_select_decoder
  import control_sequencer_pkg::*;
(
  input  logic             en,
  input  logic [REG_W-1:0] sel,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for a single-bus datapath: fetch (T0-T2) then a
// three-step register-register ALU execute (T3-T5); illegal opcodes halt.
// Ports: Clock/Clear (async active-low), Run, MemRdy, IR in; bus drive
// enables, register load enables, IncPC/Read, ALUop, one-hot Rin/Rout,
// Busy and Halted out. Outputs are a Moore decode of the state register and
// the IR fields, so Clear zeroes them immediately through the state reset.
module control_sequencer
  import control_sequencer_pkg::*;
(
  input  logic               Clock,
  input  logic               Clear,
  input  logic               Run,
  input  logic               MemRdy,
  input  logic [IR_W-1:0]    IR,
  output logic               PCout,
  output logic               Zlowout,
  output logic               MDRout,
  output logic               MARin,
  output logic               PCin,
  output logic               MDRin,
  output logic               IRin,
  output logic               Yin,
  output logic               Zin,
  output logic               IncPC,
  output logic               Read,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [NREGS-1:0]   Rin,
  output logic [NREGS-1:0]   Rout,
  output logic               Busy,
  output logic               Halted
);

  state_e              state;
  logic [OPCODE_W-1:0] opcode;
  logic [REG_W-1:0]    ra, rb, rc;
  logic                legal;
  logic                rin_en, rout_en;
  logic [REG_W-1:0]    rout_sel;
  logic                unused_ir_low;

  assign opcode        = IR[OPCODE_LSB +: OPCODE_W];
  assign ra            = IR[RA_LSB +: REG_W];
  assign rb            = IR[RB_LSB +: REG_W];
  assign rc            = IR[RC_LSB +: REG_W];
  assign legal         = is_legal_op(opcode);
  assign unused_ir_low = ^IR[RC_LSB-1:0];

  // State register; Run is looked at only in IDLE and T5
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (Run) state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    if (MemRdy) state <= S_T2;
        S_T2:    state <= S_T3;
        S_T3:    state <= legal ? S_T4 : S_HALT;
        S_T4:    state <= S_T5;
        S_T5:    state <= Run ? S_T0 : S_IDLE;
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Control word decode
  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ALUop    = ALU_NOP;
    rin_en   = 1'b0;
    rout_en  = 1'b0;
    rout_sel = '0;
    Busy     = (state != S_IDLE) && (state != S_HALT);
    Halted   = (state == S_HALT);
    case (state)
      S_T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        // Illegal opcode: nothing asserted, next edge halts
        if (legal) begin
          rout_en  = 1'b1;
          rout_sel = rb;
          Yin      = 1'b1;
        end
      end
      S_T4: begin
        rout_en  = 1'b1;
        rout_sel = rc;
        Zin      = 1'b1;
        ALUop    = alu_code(opcode);
      end
      S_T5: begin
        Zlowout = 1'b1;
        rin_en  = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decoder u_rin_dec (
    .en     (rin_en),
    .sel    (ra),
    .onehot (Rin)
  );

  reg_select_decoder u_rout_dec (
    .en     (rout_en),
    .sel    (rout_sel),
    .onehot (Rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a register-transfer level model
// of the instruction cycle predicts the full control word, checked every
// falling edge, plus directed literal checks at key points.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        run = 1'b0;
  logic        memrdy = 1'b0;
  logic [31:0] ir = 32'h0;

  logic        pcout, zlowout, mdrout, marin, pcin, mdrin, irin, yin, zin, incpc, rd;
  logic [4:0]  aluop;
  logic [15:0] rin, rout;
  logic        busy, halted;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  control_sequencer dut (
    .Clock   (clk),
    .Clear   (clear),
    .Run     (run),
    .MemRdy  (memrdy),
    .IR      (ir),
    .PCout   (pcout),
    .Zlowout (zlowout),
    .MDRout  (mdrout),
    .MARin   (marin),
    .PCin    (pcin),
    .MDRin   (mdrin),
    .IRin    (irin),
    .Yin     (yin),
    .Zin     (zin),
    .IncPC   (incpc),
    .Read    (rd),
    .ALUop   (aluop),
    .Rin     (rin),
    .Rout    (rout),
    .Busy    (busy),
    .Halted  (halted)
  );

  // Control word: 11 strobes, ALUop, Rin, Rout, Busy, Halted
  logic [49:0] act;
  assign act = {pcout, zlowout, mdrout, marin, pcin, mdrin, irin, yin, zin, incpc, rd,
                aluop, rin, rout, busy, halted};

  // Model: which micro-step of the instruction cycle we are in
  localparam int M_IDLE = -1;
  localparam int M_HALT = -2;
  int step = M_IDLE;

  function automatic bit op_ok(input logic [4:0] op);
    return op == 5'd3 || op == 5'd4 || op == 5'd8 || op == 5'd9;
  endfunction

  function automatic logic [4:0] op_alu(input logic [4:0] op);
    case (op)
      5'd3:    return 5'd4;   // ADD
      5'd4:    return 5'd5;   // SUB
      5'd8:    return 5'd9;   // AND
      5'd9:    return 5'd10;  // OR
      default: return 5'd0;
    endcase
  endfunction

  // Register transfers of each step expressed as the expected control word
  function automatic logic [49:0] expected(input int s, input logic [31:0] w);
    logic [10:0] strobes;  // PCout Zlow MDRout MARin PCin MDRin IRin Yin Zin IncPC Read
    logic [4:0]  alu;
    logic [15:0] ri, ro;
    logic        bz, hl;
    logic [4:0]  op;
    op      = w[31:27];
    strobes = '0;
    alu     = '0;
    ri      = '0;
    ro      = '0;
    bz      = (s >= 0);
    hl      = (s == M_HALT);
    case (s)
      0: strobes = 11'b100_1000_0110;                  // PC->MAR, PC+1->Z
      1: strobes = 11'b010_0110_0001;                  // Z->PC, M[MAR]->MDR
      2: strobes = 11'b001_0001_0000;                  // MDR->IR
      3: if (op_ok(op)) begin                           // rb->Y
           strobes = 11'b000_0000_1000;
           ro      = 16'(1) << w[22:19];
         end
      4: begin                                          // Y op rc -> Z
           strobes = 11'b000_0000_0100;
           ro      = 16'(1) << w[18:15];
           alu     = op_alu(op);
         end
      5: begin                                          // Z->ra
           strobes = 11'b010_0000_0000;
           ri      = 16'(1) << w[26:23];
         end
      default: ;
    endcase
    return {strobes, alu, ri, ro, bz, hl};
  endfunction

  always @(posedge clk or negedge clear) begin
    if (!clear) step <= M_IDLE;
    else begin
      case (step)
        M_IDLE:  if (run) step <= 0;
        M_HALT:  step <= M_HALT;
        1:       if (memrdy) step <= 2;
        3:       step <= op_ok(ir[31:27]) ? 4 : M_HALT;
        5:       step <= run ? 0 : M_IDLE;
        default: step <= step + 1;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  always @(negedge clk) chk("ctrl_word", 64'(act), 64'(expected(step, ir)));

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tick(2);
    chk("reset_word", 64'(act), 64'd0);

    // OR R5,R2,R4 with memory always ready
    clear = 1'b1; run = 1'b1; memrdy = 1'b1; ir = 32'h4A920000;
    tick(4);
    chk("or_t3_rout", 64'(rout), 64'h0004);
    chk("or_t3_yin", 64'(yin), 64'd1);
    tick(1);
    chk("or_t4_rout", 64'(rout), 64'h0010);
    chk("or_t4_alu", 64'(aluop), 64'b01010);
    chk("or_t4_zin", 64'(zin), 64'd1);
    tick(1);
    chk("or_t5_rin", 64'(rin), 64'h0020);
    chk("or_t5_zlow", 64'(zlowout), 64'd1);
    tick(1);
    chk("t5_to_t0", 64'({pcout, busy}), 64'b11);

    // Fetch with memory stalled 3 cycles: T1 lasts 4 cycles
    memrdy = 1'b0;
    tick(1);
    chk("t1_read_0", 64'(rd), 64'd1);
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk("t1_read_wait", 64'(rd), 64'd1);
    end
    memrdy = 1'b1; ir = 32'h19110000;  // ADD R2,R2,R2 (ra=rb=rc=2)
    tick(1);
    chk("t2_after_wait", 64'({irin, rd}), 64'b10);
    tick(1);
    chk("add_t3_rout", 64'(rout), 64'h0004);
    tick(1);
    chk("add_t4_rout", 64'(rout), 64'h0004);
    chk("add_t4_alu", 64'(aluop), 64'b00100);
    tick(1);
    chk("add_t5_rin", 64'(rin), 64'h0004);
    run = 1'b0;
    tick(1);
    chk("t5_to_idle", 64'({busy, pcout}), 64'd0);

    // Clear mid-T1 (memory not ready)
    run = 1'b1; memrdy = 1'b0;
    tick(2);
    chk("pre_clr_t1", 64'(rd), 64'd1);
    #2 clear = 1'b0;
    #1 chk("clr_t1_word", 64'(act), 64'd0);
    tick(1);
    clear = 1'b1;

    // Clear mid-T4
    memrdy = 1'b1; ir = 32'h4A920000;
    tick(5);
    chk("pre_clr_t4", 64'(aluop), 64'b01010);
    #2 clear = 1'b0;
    #1 chk("clr_t4_word", 64'(act), 64'd0);
    tick(1);
    clear = 1'b1;

    // Illegal opcode halts
    ir = 32'hF8000000;
    tick(4);
    chk("illegal_t3", 64'(act), 64'd2);  // only Busy
    tick(1);
    chk("halt_word", 64'(act), 64'd1);   // only Halted
    tick(5);
    chk("halt_stays", 64'(act), 64'd1);
    #2 clear = 1'b0;
    #1 chk("halt_cleared", 64'(act), 64'd0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
